// File: rtl/rng_digits.sv
// rng_digits: button-timed decimal digit generator.
//
// The time GEN is held seeds a 32-bit Galois LFSR. NUM_DIGITS decimal digits
// are then drawn from the LFSR by rejection sampling, optionally without
// repeats. The result is presented atomically on RN with a one-cycle VALID.
//
// Parameters:
//   NUM_DIGITS   number of digits produced (1..10)
//   CNT_W        hold-time counter width (8..32)
//   ALLOW_REPEAT 1 = digits may repeat, 0 = all digits distinct
//
// Ports:
//   CLK    in   system clock, rising edge
//   RST_N  in   asynchronous active-low reset
//   GEN    in   asynchronous button level, high while held
//   RN     out  digit i at RN[4*i+3:4*i], i=0 generated first
//   VALID  out  one-cycle pulse when RN has just been updated
//   BUSY   out  high from the start of extraction until the result is out
module rng_digits #(
  parameter int NUM_DIGITS   = 4,
  parameter int CNT_W        = 32,
  parameter int ALLOW_REPEAT = 1
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    GEN,
  output logic [4*NUM_DIGITS-1:0] RN,
  output logic                    VALID,
  output logic                    BUSY
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXTRACT = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [31:0] LFSR_ONE  = 32'h0000_0001;

  // One Galois step: shift right, fold in the tap mask when a 1 falls out.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? LFSR_MASK : 32'h0000_0000);
  endfunction

  state_e                  state_q, state_d;
  logic                    sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [31:0]             lfsr_q, lfsr_d;
  logic [15:0]             used_q, used_d;
  logic [3:0]              idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0] rn_q, rn_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;

  logic                    gen_s, rise_s, fall_s;
  logic [31:0]             count_ext_s, seed_s, lfsr_nx_s;
  logic [3:0]              cand_s;
  logic                    accept_s;

  assign gen_s  = sync2_q;
  assign rise_s = gen_s & ~prev_q;
  assign fall_s = ~gen_s & prev_q;

  // Synchroniser, edge-detect history and all registered state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      count_q  <= {CNT_W{1'b0}};
      lfsr_q   <= LFSR_ONE;
      used_q   <= 16'h0000;
      idx_q    <= 4'd0;
      shadow_q <= {(4*NUM_DIGITS){1'b0}};
      rn_q     <= {(4*NUM_DIGITS){1'b0}};
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      state_q  <= S_IDLE;
    end else begin
      sync1_q  <= GEN;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      count_q  <= count_d;
      lfsr_q   <= lfsr_d;
      used_q   <= used_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      rn_q     <= rn_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      state_q  <= state_d;
    end
  end

  // Hold counter: a rising edge restarts the count, and that first high
  // cycle already counts, so count equals the number of synced high cycles.
  always_comb begin
    count_d = count_q;
    if (gen_s) begin
      count_d = (rise_s ? {CNT_W{1'b0}} : count_q) + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Seed and candidate datapath.
  always_comb begin
    count_ext_s              = 32'h0000_0000;
    count_ext_s[CNT_W-1:0]   = count_q;
    seed_s                   = lfsr_q ^ count_ext_s;
    lfsr_nx_s                = lfsr_step(lfsr_q);
    cand_s                   = lfsr_nx_s[3:0];
    accept_s = (cand_s <= 4'd9) && ((ALLOW_REPEAT != 0) || !used_q[cand_s]);
  end

  // Next-state logic and registered-output next values.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    used_d   = used_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    case (state_q)
      S_IDLE: begin
        if (fall_s) begin
          lfsr_d  = (seed_s == 32'h0000_0000) ? LFSR_ONE : seed_s;
          used_d  = 16'h0000;
          idx_d   = 4'd0;
          state_d = S_EXTRACT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXTRACT: begin
        lfsr_d = lfsr_nx_s;
        if (accept_s) begin
          shadow_d[{idx_q, 2'b00} +: 4] = cand_s;
          used_d[cand_s]                = 1'b1;
          if (idx_q == 4'(NUM_DIGITS - 1)) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          state_d = S_EXTRACT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // RN and VALID change together on entry to DONE; the final digit is
    // taken from shadow_d so the whole word lands in one update.
    if (state_d == S_DONE && state_q == S_EXTRACT) begin
      rn_d    = shadow_d;
      valid_d = 1'b1;
    end else begin
      rn_d    = rn_q;
      valid_d = 1'b0;
    end
    busy_d = (state_d != S_IDLE);
  end

  assign RN    = rn_q;
  assign VALID = valid_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_rng_digits.sv
module tb_rng_digits;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        gen_a, gen_b;
  logic [15:0] rn_a;
  logic        valid_a, busy_a;
  logic [39:0] rn_b;
  logic        valid_b, busy_b;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] lfsr_m [2];

  always #5 clk = ~clk;

  // Instance 0: default parameters (4 digits, repeats allowed).
  rng_digits u_dflt (
    .CLK(clk), .RST_N(rst_n), .GEN(gen_a),
    .RN(rn_a), .VALID(valid_a), .BUSY(busy_a)
  );

  // Instance 1: 10 distinct digits.
  rng_digits #(.NUM_DIGITS(10), .CNT_W(32), .ALLOW_REPEAT(0)) u_perm (
    .CLK(clk), .RST_N(rst_n), .GEN(gen_b),
    .RN(rn_b), .VALID(valid_b), .BUSY(busy_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rn_of(input int w);
    return (w == 0) ? {48'h0, rn_a} : {24'h0, rn_b};
  endfunction
  function automatic logic valid_of(input int w);
    return (w == 0) ? valid_a : valid_b;
  endfunction
  function automatic logic busy_of(input int w);
    return (w == 0) ? busy_a : busy_b;
  endfunction

  task automatic set_gen(input int w, input logic b);
    if (w == 0) gen_a = b;
    else        gen_b = b;
  endtask

  // Reference: seed from state and hold count, draw digits by rejection.
  // Returns the packed digits, the number of LFSR steps taken and the final LFSR.
  task automatic model(input int w, input logic [31:0] cnt,
                       output logic [63:0] rn, output int steps, output logic [31:0] l_out);
    int     nd;
    bit     rep;
    bit     seen [10];
    int     got;
    int     d;
    logic [31:0] l;
    nd  = (w == 0) ? 4 : 10;
    rep = (w == 0);
    foreach (seen[i]) seen[i] = 1'b0;
    l = lfsr_m[w] ^ cnt;
    if (l == 32'h0) l = 32'h1;
    rn = 64'h0;
    steps = 0;
    got = 0;
    while (got < nd && steps < 100000) begin
      if (l % 2 == 1) l = (l / 2) ^ 32'h8020_0003;
      else            l = l / 2;
      steps++;
      d = int'(l % 16);
      if (d < 10 && (rep || !seen[d])) begin
        rn = rn | (64'(d) << (4 * got));
        seen[d] = 1'b1;
        got++;
      end
    end
    l_out = l;
  endtask

  // One press of 'hold' synced cycles on instance w. Optionally a second
  // press is made and released while busy, or reset is asserted at edge abort_at.
  task automatic run_press(input int w, input int hold, input bit extra, input int abort_at);
    logic [63:0] exp_rn, rn_v;
    logic [31:0] l_next;
    int          k, vcnt, vedge, last;
    bit          ok;
    logic [9:0]  seen_mask;
    model(w, 32'(hold), exp_rn, k, l_next);
    @(negedge clk) set_gen(w, 1'b1);
    repeat (hold) @(posedge clk);
    @(negedge clk) set_gen(w, 1'b0);
    last  = 3 + k + (extra ? 50 : 5);
    vcnt  = 0;
    vedge = -1;
    rn_v  = 64'h0;
    for (int e = 1; e <= last; e++) begin
      @(posedge clk);
      #1;
      if (e == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy_of(w)), 64'h0);
        check("abort_rn", rn_of(w), 64'h0);
        check("abort_valid", 64'(valid_of(w)), 64'h0);
        lfsr_m[0] = 32'h1;
        lfsr_m[1] = 32'h1;
        @(negedge clk) rst_n = 1'b1;
        return;
      end
      if (e == 2) check("busy_before", 64'(busy_of(w)), 64'h0);
      if (e == 3) check("busy_rise", 64'(busy_of(w)), 64'h1);
      if (extra && e == 3) set_gen(w, 1'b1);
      if (extra && e == 6) set_gen(w, 1'b0);
      if (valid_of(w)) begin
        vcnt++;
        if (vedge < 0) begin
          vedge = e;
          rn_v  = rn_of(w);
        end
      end
      if (e == 4 + k) check("busy_fall", 64'(busy_of(w)), 64'h0);
    end
    check("valid_count", 64'(vcnt), 64'h1);
    check("valid_latency", 64'(vedge), 64'(3 + k));
    check("rn_value", rn_v, exp_rn);
    check("rn_hold", rn_of(w), exp_rn);
    if (w == 0) begin
      ok = 1'b1;
      for (int i = 0; i < 4; i++) if (rn_v[4*i +: 4] > 4'd9) ok = 1'b0;
      check("digit_range", 64'(ok), 64'h1);
    end else begin
      seen_mask = 10'h0;
      for (int i = 0; i < 10; i++) begin
        if (rn_v[4*i +: 4] <= 4'd9) seen_mask[rn_v[4*i +: 4]] = 1'b1;
      end
      check("permutation", 64'(seen_mask), 64'h3ff);
    end
    lfsr_m[w] = l_next;
  endtask

  task automatic idle_no_valid(input string tag, input int cycles);
    int cnt;
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (valid_a || valid_b) cnt++;
    end
    check(tag, 64'(cnt), 64'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    gen_a = 1'b0;
    gen_b = 1'b0;
    lfsr_m[0] = 32'h1;
    lfsr_m[1] = 32'h1;
    #12;
    check("rst_rn_a", {48'h0, rn_a}, 64'h0);
    check("rst_valid_a", 64'(valid_a), 64'h0);
    check("rst_busy_a", 64'(busy_a), 64'h0);
    check("rst_rn_b", {24'h0, rn_b}, 64'h0);
    @(negedge clk) rst_n = 1'b1;
    idle_no_valid("idle_after_reset", 50);

    // Hold 100 from reset: seed 1 ^ 100 = 0x65.
    run_press(0, 100, 1'b0, 0);

    // Reset during extraction, then no VALID on release.
    run_press(0, 30, 1'b0, 5);
    idle_no_valid("no_valid_post_abort", 30);

    // One synced cycle from reset: seed 1 ^ 1 = 0, forced to 1.
    run_press(0, 1, 1'b0, 0);

    for (int i = 0; i < 10; i++) run_press(0, int'($urandom_range(1, 60)), 1'b0, 0);

    // Distinct-digit instance, with one release ignored while busy.
    for (int i = 0; i < 200; i++) run_press(1, int'($urandom_range(1, 40)), (i == 50), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rng_digits.md
Name: rng_digits

Overview:
- Parametrised successor to the button-timed digit generator.
- The human hold time of GEN seeds a 32-bit Galois LFSR. The block then extracts NUM_DIGITS decimal digits (0-9) by rejection sampling, optionally with no repeated digits (code-breaker style games).
- Sits between the debounced button input and the game/display logic. Results are delivered atomically with a one-cycle VALID strobe.

Parameters:
- NUM_DIGITS, 4, number of decimal digits produced; legal 1..10.
- CNT_W, 32, width of the hold-time counter; legal 8..32.
- ALLOW_REPEAT, 1, 1 = digits may repeat; 0 = all digits distinct (requires NUM_DIGITS <= 10).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- GEN  in  1  asynchronous button level, high while held.
- RN  out  4*NUM_DIGITS  digit i (binary 0-9) at RN[4*i+3:4*i]; i=0 is the first digit generated.
- VALID  out  1  one-cycle pulse when RN has just been updated.
- BUSY  out  1  high while digits are being extracted.

Behaviour:
- Reset (RST_N low, async): RN=0, VALID=0, BUSY=0, count=0, lfsr=32'h0000_0001, used mask=0, digit index=0, state=IDLE, synchroniser flops=0.
- Input conditioning:
  - GEN passes through a 2-flop synchroniser, giving gen_s.
  - Edge detect compares gen_s with its previous value.
  - A pin transition reaches the edge detector 2 CLK later.
- Hold counter:
  - Cleared to 0 on a gen_s rising edge.
  - Incremented by 1 every cycle gen_s is high; wraps modulo 2^CNT_W.
  - Runs in every state.
- States: IDLE, EXTRACT, DONE.
- IDLE:
  - LFSR holds its value.
  - On a gen_s falling edge: seed = lfsr XOR zero-extended count.
  - If seed == 0, load 32'h0000_0001 instead.
  - Clear used mask and index, set BUSY=1, go to EXTRACT.
  - The seed uses the counter value before that cycle's update.
- EXTRACT:
  - Each cycle the LFSR advances one step: Galois, taps 32,22,2,1, mask 32'h8020_0003, shift right, XOR mask when the shifted-out bit is 1.
  - Candidate = new lfsr[3:0].
  - Accept when candidate <= 9 AND (ALLOW_REPEAT==1 OR used[candidate]==0).
  - On accept: write the candidate into the shadow digit slot [index], set used[candidate], index++.
  - On reject: no change apart from the LFSR.
  - When the accepted count reaches NUM_DIGITS, go to DONE.
  - The maximal-length LFSR guarantees termination.
- DONE (1 cycle):
  - Copy the shadow register to RN in one update; RN never shows a partial result.
  - VALID=1 for this cycle only; BUSY=0 on the next cycle; return to IDLE.
  - The LFSR keeps its final state, chaining entropy into the next press.
- gen_s edges while BUSY or in DONE:
  - The counter still clears and counts.
  - Falling edges are ignored; no queued request.
  - A press whose release occurs during EXTRACT produces no new result.
- Minimum latency: synced fall to VALID = 1 (IDLE->EXTRACT) + NUM_DIGITS accepts + 1 (DONE) cycles.
- RN holds its value until the next DONE.
- Reset mid-EXTRACT:
  - All state returns to reset values immediately.
  - RN=0; no VALID is emitted on reset release.
- Width rule: when CNT_W < 32, count is zero-extended before the XOR.

Test Plan:
- Reset: assert RST_N=0 mid-cycle -> RN=0, VALID=0, BUSY=0 asynchronously; after release with GEN=0 for 50 cycles -> no VALID.
- Default params, hold GEN 100 cycles then release:
  - BUSY rises exactly 3 CLK after the GEN pin falls.
  - Exactly one VALID pulse follows.
  - Every RN nibble is <= 9.
  - RN and cycle count match the bit-accurate model (count=100 -> seed 32'h65).
- ALLOW_REPEAT=0, NUM_DIGITS=10, 200 random-length presses -> every result is a permutation of 0..9; VALID count = 200.
- Zero seed: hold GEN exactly 1 synced cycle from reset (count=1, lfsr=1 -> seed 0) -> seed forced to 1; output matches the model.
- Press/release during BUSY (NUM_DIGITS=10, ALLOW_REPEAT=0) -> that release ignored; only one VALID; RN unchanged until the next valid release.
- Assert RST_N during EXTRACT -> BUSY=0, RN=0 immediately; the following press yields a normal result matching the model from the reset state.
